// File: rtl/plic_acc_arb_pkg.sv
// Shared types for the per-hart register-file access arbiter.
// Latency: n/a (types only). Backpressure: n/a.
// Struct widths follow the default arbiter geometry below.
package plic_acc_arb_pkg;

    localparam int ACC_NUM_REQ    = 2;
    localparam int ACC_NUM_DOMAIN = 16;
    localparam int ACC_DATA_W     = 32;
    localparam int ACC_ADDR_W     = 14;
    localparam int ACC_DOMAIN_W   = (ACC_NUM_DOMAIN == 1) ? 1 : $clog2(ACC_NUM_DOMAIN);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} acc_state_e;

    typedef struct packed {
        logic [ACC_ADDR_W-1:0]     addr;
        logic                      rwb;
        logic [ACC_DATA_W/8-1:0]   wm;
        logic [ACC_DATA_W-1:0]     wdata;
        logic [1:0]                priv_mode;
        logic [ACC_DOMAIN_W-1:0]   did;
    } acc_req_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/plic_rr_arbiter.sv
// Round-robin pick: first set request at or above ptr_i, wrapping modulo N.
// Latency: combinational. Backpressure: none, caller gates the grant.
// Outputs a one-hot grant, its index and an any-grant flag.
module plic_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N == 1) ? 1 : $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_gnt_o
);

    int cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        cand      = 0;
        for (int off = 0; off < N; off++) begin
            cand = int'(ptr_i) + off;
            if (cand >= N) cand = cand - N;
            if (!any_gnt_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = IDX_W'(cand);
                any_gnt_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/plic_hart_acc_arb.sv
// Shares one hart register-file port among NUM_REQ requesters, round-robin.
// Latency: grant T, csb low T+1, capture T+2, response valid from T+3.
// Backpressure: response held until owner's rsp_ready_i; no grant outside IDLE.
module plic_hart_acc_arb
    import plic_acc_arb_pkg::*;
#(
    parameter int NUM_REQ        = ACC_NUM_REQ,
    parameter int NUM_DOMAIN     = ACC_NUM_DOMAIN,
    parameter int DATA_WIDTH     = ACC_DATA_W,
    parameter int MEM_ADDR_WIDTH = ACC_ADDR_W,
    parameter int DOMAIN_W       = (NUM_DOMAIN == 1) ? 1 : $clog2(NUM_DOMAIN),
    parameter int REQ_W          = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ)
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ*MEM_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]                req_rwb_i,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_wm_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata_i,
    input  logic [NUM_REQ*2-1:0]              req_priv_mode_i,
    input  logic [NUM_REQ*DOMAIN_W-1:0]       req_did_i,
    output logic [NUM_REQ-1:0]                rsp_valid_o,
    input  logic [NUM_REQ-1:0]                rsp_ready_i,
    output logic [DATA_WIDTH-1:0]             rsp_rdata_o,
    output logic                              rsp_error_o,
    output logic                              hart_acc_csb_o,
    output logic [MEM_ADDR_WIDTH-1:0]         hart_acc_addr_o,
    output logic                              hart_acc_rwb_o,
    output logic [DATA_WIDTH/8-1:0]           hart_acc_wm_o,
    output logic [DATA_WIDTH-1:0]             hart_acc_wdata_o,
    output logic [1:0]                        acc_priv_mode_o,
    output logic [DOMAIN_W-1:0]               acc_did_o,
    input  logic [DATA_WIDTH-1:0]             hart_acc_rdata_i,
    input  logic                              error_i
);

    localparam int WM_W = DATA_WIDTH / 8;

    acc_state_e             state_q, state_d;
    logic [REQ_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [REQ_W-1:0]       owner_q, owner_d;
    acc_req_t               acc_q, acc_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_error_q, rsp_error_d;

    logic [NUM_REQ-1:0]     gnt_oh;
    logic [REQ_W-1:0]       gnt_idx;
    logic                   any_gnt;

    plic_rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (REQ_W)
    ) u_rr_arbiter (
        .req_i     (req_valid_i),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .any_gnt_o (any_gnt)
    );

    // Ready mirrors the arbiter pick only in IDLE, so any_gnt there is a handshake.
    assign req_ready_o = (state_q == IDLE) ? gnt_oh : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        acc_d       = acc_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        case (state_q)
            IDLE: begin
                if (any_gnt) begin
                    acc_d.addr      = req_addr_i[int'(gnt_idx)*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
                    acc_d.rwb       = req_rwb_i[gnt_idx];
                    acc_d.wm        = req_wm_i[int'(gnt_idx)*WM_W +: WM_W];
                    acc_d.wdata     = req_wdata_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                    acc_d.priv_mode = req_priv_mode_i[int'(gnt_idx)*2 +: 2];
                    acc_d.did       = req_did_i[int'(gnt_idx)*DOMAIN_W +: DOMAIN_W];
                    owner_d         = gnt_idx;
                    rr_ptr_d        = REQ_W'(rr_next(32'(gnt_idx), NUM_REQ));
                    state_d         = ISSUE;
                end
            end
            ISSUE: state_d = CAPT;
            CAPT: begin
                rsp_rdata_d = acc_q.rwb ? '0 : hart_acc_rdata_i;
                rsp_error_d = error_i;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready_i[owner_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            acc_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            acc_q       <= acc_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_o[i] = (state_q == RESP) && (owner_q == REQ_W'(i));
        end
    end

    assign rsp_rdata_o      = rsp_rdata_q;
    assign rsp_error_o      = rsp_error_q;
    assign hart_acc_csb_o   = (state_q != ISSUE);
    assign hart_acc_addr_o  = acc_q.addr;
    assign hart_acc_rwb_o   = acc_q.rwb;
    assign hart_acc_wm_o    = acc_q.wm;
    assign hart_acc_wdata_o = acc_q.wdata;
    assign acc_priv_mode_o  = acc_q.priv_mode;
    assign acc_did_o        = acc_q.did;

endmodule

// File: tb/tb_plic_hart_acc_arb.sv
// Bench for plic_hart_acc_arb: register-file model plus response scoreboard.
module tb_plic_hart_acc_arb;

    localparam int NR  = 2;
    localparam int DW  = 32;
    localparam int AW  = 14;
    localparam int DMW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_rwb;
    logic [NR*4-1:0]   req_wm;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*2-1:0]   req_priv;
    logic [NR*DMW-1:0] req_did;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_error;
    logic              csb;
    logic [AW-1:0]     acc_addr;
    logic              acc_rwb;
    logic [3:0]        acc_wm;
    logic [DW-1:0]     acc_wdata;
    logic [1:0]        acc_priv;
    logic [DMW-1:0]    acc_did;
    logic [DW-1:0]     hart_rdata;
    logic              hart_err;

    typedef struct {
        int          owner;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          mon_owner;
    int          n_vec = 0;
    int          n_err = 0;
    logic [AW-1:0] rf_err_addr = 14'h3FFF;

    plic_hart_acc_arb dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_addr_i       (req_addr),
        .req_rwb_i        (req_rwb),
        .req_wm_i         (req_wm),
        .req_wdata_i      (req_wdata),
        .req_priv_mode_i  (req_priv),
        .req_did_i        (req_did),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_rdata_o      (rsp_rdata),
        .rsp_error_o      (rsp_error),
        .hart_acc_csb_o   (csb),
        .hart_acc_addr_o  (acc_addr),
        .hart_acc_rwb_o   (acc_rwb),
        .hart_acc_wm_o    (acc_wm),
        .hart_acc_wdata_o (acc_wdata),
        .acc_priv_mode_o  (acc_priv),
        .acc_did_o        (acc_did),
        .hart_acc_rdata_i (hart_rdata),
        .error_i          (hart_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rf_data(input logic [AW-1:0] a);
        return (a == 14'h010) ? 32'hDEAD_BEEF : {16'hC0DE, 2'b00, a};
    endfunction

    // Registered register file: valid only the cycle after csb low, garbage otherwise.
    always @(posedge clk) begin
        if (!csb) begin
            hart_rdata <= rf_data(acc_addr);
            hart_err   <= (acc_addr == rf_err_addr);
        end else begin
            hart_rdata <= 32'h0BAD_F00D;
            hart_err   <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && |(rsp_valid & rsp_ready)) begin
            mon_owner = rsp_valid[1] ? 1 : 0;
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: got owner %0d, want no response", mon_owner);
            end else begin
                mon_e = sb_q.pop_front();
                if (rsp_valid === 2'b11 || mon_owner !== mon_e.owner) begin
                    n_err++;
                    $display("FAIL rsp_owner: got %b, want owner %0d", rsp_valid, mon_e.owner);
                end
                n_vec++;
                if (rsp_rdata !== mon_e.rdata) begin
                    n_err++;
                    $display("FAIL rsp_rdata: got %h, want %h", rsp_rdata, mon_e.rdata);
                end
                n_vec++;
                if (rsp_error !== mon_e.err) begin
                    n_err++;
                    $display("FAIL rsp_error: got %b, want %b", rsp_error, mon_e.err);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [AW-1:0] a, input logic rwb, input logic [3:0] wm,
                           input logic [31:0] wd, input logic [1:0] pm, input logic [DMW-1:0] did);
        req_valid[r]             = 1'b1;
        req_addr[r*AW +: AW]     = a;
        req_rwb[r]               = rwb;
        req_wm[r*4 +: 4]         = wm;
        req_wdata[r*DW +: DW]    = wd;
        req_priv[r*2 +: 2]       = pm;
        req_did[r*DMW +: DMW]    = did;
    endtask

    task automatic push_exp(input int r);
        exp_t e;
        logic [AW-1:0] a;
        a       = req_addr[r*AW +: AW];
        e.owner = r;
        e.rdata = req_rwb[r] ? 32'h0 : rf_data(a);
        e.err   = (a == rf_err_addr);
        sb_q.push_back(e);
    endtask

    task automatic wait_ready(output int n);
        #1;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 2'b11;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0; req_addr = '0; req_rwb = '0; req_wm = '0;
        req_wdata = '0; req_priv = '0; req_did = '0; rsp_ready = 2'b11;
        step();
        step();
        n_vec++;
        if ({csb, req_ready, rsp_valid, rsp_error} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, want 100000", {csb, req_ready, rsp_valid, rsp_error});
        end
        n_vec++;
        if (rsp_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h, want 0", rsp_rdata);
        end
        n_vec++;
        if ({acc_addr, acc_rwb, acc_wm, acc_wdata, acc_priv, acc_did} !== '0) begin
            n_err++;
            $display("FAIL reset_fields: got %h, want 0", {acc_addr, acc_rwb, acc_wm, acc_wdata, acc_priv, acc_did});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read_sideband();
        set_req(0, 14'h010, 1'b0, 4'h0, 32'h0, 2'b01, 4'd3);
        #1;
        n_vec++;
        if ({req_ready, csb} !== 3'b011) begin
            n_err++;
            $display("FAIL single_grant: got ready/csb %b, want 011", {req_ready, csb});
        end
        push_exp(0);
        step();
        req_valid[0] = 1'b0;
        #1;
        n_vec++;
        if ({csb, acc_addr, acc_rwb, req_ready} !== {1'b0, 14'h010, 1'b0, 2'b00}) begin
            n_err++;
            $display("FAIL single_issue: got csb %b addr %h rwb %b ready %b", csb, acc_addr, acc_rwb, req_ready);
        end
        n_vec++;
        if ({acc_priv, acc_did} !== {2'b01, 4'd3}) begin
            n_err++;
            $display("FAIL sideband_t1: got priv %b did %0d, want 01 3", acc_priv, acc_did);
        end
        step();
        n_vec++;
        if ({csb, rsp_valid, acc_priv, acc_did} !== {1'b1, 2'b00, 2'b01, 4'd3}) begin
            n_err++;
            $display("FAIL sideband_t2: got csb %b rsp %b priv %b did %0d", csb, rsp_valid, acc_priv, acc_did);
        end
        step();
        n_vec++;
        if ({rsp_valid, rsp_rdata, rsp_error} !== {2'b01, 32'hDEAD_BEEF, 1'b0}) begin
            n_err++;
            $display("FAIL single_rsp: got valid %b rdata %h err %b", rsp_valid, rsp_rdata, rsp_error);
        end
        step();
        n_vec++;
        if (rsp_valid !== 2'b00) begin
            n_err++;
            $display("FAIL single_rsp_done: got %b, want 00", rsp_valid);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        apply_reset();
        set_req(0, 14'h040, 1'b0, 4'h0, 32'h0, 2'b00, 4'd0);
        set_req(1, 14'h041, 1'b0, 4'h0, 32'h0, 2'b00, 4'd1);
        #1;
        n_vec++;
        if (req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL sim_first: got %b, want 01", req_ready);
        end
        push_exp(0);
        step();
        req_valid[0] = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL sim_loser_wait: got %b, want 00", req_ready);
        end
        wait_ready(n);
        n_vec++;
        if (req_ready !== 2'b10 || n != 3) begin
            n_err++;
            $display("FAIL sim_second: got %b after %0d cycles, want 10 after 3", req_ready, n);
        end
        push_exp(1);
        step();
        set_req(0, 14'h043, 1'b0, 4'h0, 32'h0, 2'b00, 4'd0);
        set_req(1, 14'h042, 1'b0, 4'h0, 32'h0, 2'b00, 4'd1);
        wait_ready(n);
        n_vec++;
        if (req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL sim_repeat: got %b, want 01", req_ready);
        end
        push_exp(0);
        step();
        req_valid[0] = 1'b0;
        wait_ready(n);
        n_vec++;
        if (req_ready !== 2'b10) begin
            n_err++;
            $display("FAIL sim_repeat_second: got %b, want 10", req_ready);
        end
        push_exp(1);
        step();
        req_valid = '0;
        repeat (4) step();
    endtask

    task automatic test_write_error();
        int n;
        rf_err_addr = 14'h024;
        set_req(1, 14'h024, 1'b1, 4'b0011, 32'h1234_5678, 2'b00, 4'd5);
        wait_ready(n);
        n_vec++;
        if (req_ready !== 2'b10) begin
            n_err++;
            $display("FAIL wr_grant: got %b, want 10", req_ready);
        end
        push_exp(1);
        step();
        req_valid[1] = 1'b0;
        n_vec++;
        if ({csb, acc_addr, acc_rwb, acc_wm, acc_wdata} !== {1'b0, 14'h024, 1'b1, 4'b0011, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL wr_fields: got csb %b addr %h rwb %b wm %b wdata %h", csb, acc_addr, acc_rwb, acc_wm, acc_wdata);
        end
        step();
        step();
        n_vec++;
        if ({rsp_valid, rsp_rdata, rsp_error} !== {2'b10, 32'h0, 1'b1}) begin
            n_err++;
            $display("FAIL wr_rsp: got valid %b rdata %h err %b, want 10 0 1", rsp_valid, rsp_rdata, rsp_error);
        end
        step();
        rf_err_addr = 14'h3FFF;
    endtask

    task automatic test_backpressure();
        int n;
        rsp_ready = 2'b00;
        set_req(0, 14'h030, 1'b0, 4'h0, 32'h0, 2'b00, 4'd0);
        wait_ready(n);
        push_exp(0);
        step();
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if ({rsp_valid, rsp_rdata, req_ready} !== {2'b01, rf_data(14'h030), 2'b00}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got valid %b rdata %h ready %b", k, rsp_valid, rsp_rdata, req_ready);
            end
            step();
        end
        req_valid[0] = 1'b0;
        rsp_ready    = 2'b01;
        step();
        n_vec++;
        if ({rsp_valid, req_ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL bp_release: got valid %b ready %b, want 00 00", rsp_valid, req_ready);
        end
        rsp_ready = 2'b11;
    endtask

    task automatic test_reset_capt();
        int n;
        set_req(0, 14'h050, 1'b0, 4'h0, 32'h0, 2'b10, 4'd7);
        wait_ready(n);
        step();
        req_valid[0] = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({csb, req_ready, rsp_valid, rsp_error, rsp_rdata} !== {1'b1, 37'h0}) begin
            n_err++;
            $display("FAIL rst_capt_ctrl: got csb %b ready %b valid %b err %b rdata %h", csb, req_ready, rsp_valid, rsp_error, rsp_rdata);
        end
        n_vec++;
        if ({acc_addr, acc_rwb, acc_wm, acc_wdata, acc_priv, acc_did} !== '0) begin
            n_err++;
            $display("FAIL rst_capt_fields: got addr %h priv %b did %0d, want 0", acc_addr, acc_priv, acc_did);
        end
        step();
        step();
        rst_n = 1'b1;
        #1;
        set_req(0, 14'h051, 1'b0, 4'h0, 32'h0, 2'b00, 4'd0);
        set_req(1, 14'h052, 1'b0, 4'h0, 32'h0, 2'b00, 4'd0);
        #1;
        n_vec++;
        if (req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL rst_rr_ptr: got %b, want 01", req_ready);
        end
        push_exp(0);
        step();
        req_valid = '0;
        step();
        step();
        n_vec++;
        if (rsp_valid !== 2'b01) begin
            n_err++;
            $display("FAIL rst_after_rsp: got %b, want 01", rsp_valid);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        set_req(0, 14'h060, 1'b0, 4'h0, 32'h0, 2'b00, 4'd0);
        wait_ready(n);
        push_exp(0);
        step();
        for (int k = 0; k < 3; k++) begin
            wait_ready(n);
            n_vec++;
            if (req_ready !== 2'b01 || n != 3) begin
                n_err++;
                $display("FAIL b2b_gap[%0d]: got ready %b after %0d cycles, want 01 after 3", k, req_ready, n);
            end
            push_exp(0);
            step();
        end
        req_valid = '0;
        repeat (5) step();
    endtask

    initial begin
        test_reset();
        test_single_read_sideband();
        test_simultaneous();
        test_write_error();
        test_backpressure();
        test_reset_capt();
        test_back_to_back();
        repeat (4) step();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d outstanding responses, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
